// File: rtl/nco_hop_sched_pkg.sv
// Shared types and constants for the NCO frequency-hop scheduler.
package nco_hop_sched_pkg;

   localparam int NCO_LAT_DEFAULT = 10;
   localparam int HOP_APR         = 32;
   localparam int HOP_DW          = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_DWELL,
      ST_HOLD
   } hop_state_e;

   // Layout of one hop command at the default widths; the FIFO stores the
   // same {phi_inc, dwell} concatenation at whatever widths the top is built.
   typedef struct packed {
      logic [HOP_APR-1:0] phi_inc;
      logic [HOP_DW-1:0]  dwell;
   } hop_entry_t;

endpackage

// File: rtl/nco_hop_fifo.sv
// Hop command FIFO. Pointers carry one extra wrap bit so full and empty are
// told apart without a separate count. With recirculate set, every pop
// writes the popped entry back at the tail in the same cycle.
module nco_hop_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic         recirculate,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_rd_en;
   logic         w_wr_en;
   logic [W-1:0] w_wr_data;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign head      = r_mem[r_rd_ptr[AW-1:0]];
   assign w_rd_en   = pop && !empty;
   assign w_wr_en   = (w_rd_en && recirculate) || (push && !full);
   assign w_wr_data = (w_rd_en && recirculate) ? head : din;

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (w_wr_en && !flush) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
      end
   end

   // Pointer update; flush empties the FIFO and wins over push and pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/nco_hop_sched.sv
// Frequency-hop scheduler in front of the NCO: applies queued hop commands
// one at a time, waits out the NCO pipeline latency, then dwells.
// Optional build macro: NCO_HOP_SCHED_REPEAT_EN (hop table loops forever).
//
// state  | meaning
// IDLE   | NCO gated off, phi_inc_o held at 0
// LOAD   | pop head entry, register new phi_inc, arm counters (1 cycle)
// SETTLE | NCO_LAT cycles while the NCO pipeline catches up
// DWELL  | output valid, count down max(dwell,1) cycles
// HOLD   | table exhausted, keep last frequency running
module nco_hop_sched
   import nco_hop_sched_pkg::*;
#(
   parameter int APR     = 32,
   parameter int DW      = 16,
   parameter int DEPTH   = 4,
   parameter int NCO_LAT = NCO_LAT_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic           abort,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [APR-1:0] cmd_phi_inc,
   input  logic [DW-1:0]  cmd_dwell,
   output logic [APR-1:0] phi_inc_o,
   output logic           nco_clken,
   output logic           hop_strobe,
   output logic           settled,
   output logic           busy
);

   localparam int LW = (NCO_LAT > 1) ? $clog2(NCO_LAT) : 1;
   localparam int EW = APR + DW;

   hop_state_e     r_state;
   hop_state_e     w_state_nxt;
   logic           w_full;
   logic           w_empty;
   logic           w_push;
   logic           w_pop;
   logic           w_recirc;
   logic           w_cmd_ready;
   logic [EW-1:0]  w_head;
   logic [APR-1:0] w_head_phi;
   logic [DW-1:0]  w_head_dwell;
   logic [APR-1:0] r_phi_inc;
   logic [DW-1:0]  r_dwell_cnt;
   logic [LW-1:0]  r_lat_cnt;
   logic           r_clken;
   logic           r_settled;
   logic           r_hop_strobe;

   assign {w_head_phi, w_head_dwell} = w_head;

`ifdef NCO_HOP_SCHED_REPEAT_EN
   // The table is frozen once running: no new commands while busy.
   assign w_cmd_ready = !w_full && (r_state == ST_IDLE);
   assign w_recirc    = 1'b1;
`else
   assign w_cmd_ready = !w_full;
   assign w_recirc    = 1'b0;
`endif

   assign w_push = cmd_valid && w_cmd_ready && !abort;
   assign w_pop  = (r_state == ST_LOAD) && !abort;

   nco_hop_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (w_push),
      .pop         (w_pop),
      .flush       (abort),
      .recirculate (w_recirc),
      .din         ({cmd_phi_inc, cmd_dwell}),
      .full        (w_full),
      .empty       (w_empty),
      .head        (w_head)
   );

   // Next-state decode. IDLE looks ahead at the incoming push so a command
   // arriving into an empty FIFO reaches LOAD on the very next cycle.
   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   if (en && (!w_empty || w_push)) w_state_nxt = ST_LOAD;
            ST_LOAD:   w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_lat_cnt == '0) w_state_nxt = ST_DWELL;
            ST_DWELL: begin
               if (r_dwell_cnt == '0) begin
                  if (!en)           w_state_nxt = ST_IDLE;
                  else if (!w_empty) w_state_nxt = ST_LOAD;
                  else               w_state_nxt = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!en)           w_state_nxt = ST_IDLE;
               else if (!w_empty) w_state_nxt = ST_LOAD;
            end
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, counters and registered NCO-facing outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_phi_inc    <= '0;
         r_dwell_cnt  <= '0;
         r_lat_cnt    <= '0;
         r_clken      <= 1'b0;
         r_settled    <= 1'b0;
         r_hop_strobe <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_clken      <= (w_state_nxt != ST_IDLE);
         r_settled    <= (w_state_nxt == ST_DWELL) || (w_state_nxt == ST_HOLD);
         r_hop_strobe <= 1'b0;
         if (abort) begin
            r_phi_inc   <= '0;
            r_dwell_cnt <= '0;
            r_lat_cnt   <= '0;
         end else begin
            case (r_state)
               ST_LOAD: begin
                  r_phi_inc    <= w_head_phi;
                  r_hop_strobe <= 1'b1;
                  r_lat_cnt    <= LW'(NCO_LAT - 1);
                  // A zero dwell still gets one settled cycle.
                  r_dwell_cnt  <= (w_head_dwell == '0) ? '0 : w_head_dwell - DW'(1);
               end
               ST_SETTLE: if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - LW'(1);
               ST_DWELL:  if (r_dwell_cnt != '0) r_dwell_cnt <= r_dwell_cnt - DW'(1);
               default: ;
            endcase
            if (w_state_nxt == ST_IDLE) r_phi_inc <= '0;
         end
      end
   end

   assign cmd_ready  = w_cmd_ready;
   assign phi_inc_o  = r_phi_inc;
   assign nco_clken  = r_clken;
   assign hop_strobe = r_hop_strobe;
   assign settled    = r_settled;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_nco_hop_sched.sv
// Self-checking bench for nco_hop_sched: expected hops (phi_inc and the
// absolute cycle of their hop_strobe) are queued as commands are driven and
// matched when the DUT strobes.
module tb_nco_hop_sched;

   localparam int APR = 32;
   localparam int DW  = 16;
   localparam int LAT = 10;

   typedef struct packed {
      logic [31:0] phi;
      logic [31:0] at;
   } hop_t;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           en = 1'b0;
   logic           abort = 1'b0;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [APR-1:0] cmd_phi_inc = '0;
   logic [DW-1:0]  cmd_dwell = '0;
   logic [APR-1:0] phi_inc_o;
   logic           nco_clken;
   logic           hop_strobe;
   logic           settled;
   logic           busy;

   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   n_strobe = 0;
   int   last_strobe = 0;
   bit   wait_settle = 1'b0;
   hop_t sb[$];

   nco_hop_sched #(
      .APR     (APR),
      .DW      (DW),
      .DEPTH   (4),
      .NCO_LAT (LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .abort       (abort),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_phi_inc (cmd_phi_inc),
      .cmd_dwell   (cmd_dwell),
      .phi_inc_o   (phi_inc_o),
      .nco_clken   (nco_clken),
      .hop_strobe  (hop_strobe),
      .settled     (settled),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_cmd(input logic [31:0] phi, input logic [15:0] dw);
      cmd_valid   = 1'b1;
      cmd_phi_inc = phi;
      cmd_dwell   = dw;
      tick(1);
      cmd_valid   = 1'b0;
   endtask

   task automatic expect_hop(input logic [31:0] phi, input int at);
      hop_t e;
      e.phi = phi;
      e.at  = 32'(at);
      sb.push_back(e);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_phi"},     64'(phi_inc_o),  64'd0);
      chk({tag, "_clken"},   64'(nco_clken),  64'd0);
      chk({tag, "_strobe"},  64'(hop_strobe), 64'd0);
      chk({tag, "_settled"}, 64'(settled),    64'd0);
      chk({tag, "_busy"},    64'(busy),       64'd0);
      chk({tag, "_ready"},   64'(cmd_ready),  64'd1);
   endtask

   // Scoreboard consumer: match each strobe and time the settle latency.
   always @(negedge clk) begin
      hop_t e;
      if (hop_strobe === 1'b1) begin
         n_strobe++;
         chk("hop_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("hop_phi", 64'(phi_inc_o), 64'(e.phi));
            chk("hop_cyc", 64'(cyc), 64'(e.at));
         end
         chk("settled_at_strobe", 64'(settled), 64'd0);
         last_strobe = cyc;
         wait_settle = 1'b1;
      end else if (wait_settle && settled === 1'b1) begin
         chk("settle_lat", 64'(cyc - last_strobe), 64'(LAT));
         wait_settle = 1'b0;
      end
   end

   initial begin
      int c;
      int t;
      int s0;
      logic [31:0] t3_phi [4];
      int          t3_dw  [4];
      t3_phi = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
      t3_dw  = '{3, 7, 1, 4};

      #2 reset = 1'b1;
      #1 chk_reset_outputs("por");
      tick(3);
      reset = 1'b0;
      tick(2);

`ifdef NCO_HOP_SCHED_REPEAT_EN
      // Two-entry table loops A,B,A,B... until abort.
      drive_cmd(32'h0A0A_0000, 16'd2);
      drive_cmd(32'h0B0B_0000, 16'd3);
      chk("rep_ready_idle", 64'(cmd_ready), 64'd1);
      c = cyc;
      t = c + 2;
      for (int i = 0; i < 3; i++) begin
         expect_hop(32'h0A0A_0000, t);
         t += 1 + LAT + 2;
         expect_hop(32'h0B0B_0000, t);
         t += 1 + LAT + 3;
      end
      en = 1'b1;
      tick(5);
      chk("rep_ready_busy", 64'(cmd_ready), 64'd0);
      tick(72 - 5);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("rep_abort_busy", 64'(busy), 64'd0);
      chk("rep_abort_phi", 64'(phi_inc_o), 64'd0);
      tick(30);
      chk("rep_strobes", 64'(n_strobe), 64'd6);
      chk("rep_sb_empty", 64'(sb.size()), 64'd0);
      en = 1'b0;
`else
      // Single hop, then parked in HOLD.
      en = 1'b1;
      c = cyc;
      expect_hop(32'h0100_0000, c + 2);
      drive_cmd(32'h0100_0000, 16'd5);
      tick(2 + LAT + 5 + 3);
      chk("single_busy", 64'(busy), 64'd1);
      chk("single_clken", 64'(nco_clken), 64'd1);
      chk("single_settled", 64'(settled), 64'd1);
      chk("single_hold_phi", 64'(phi_inc_o), 64'h0100_0000);
      chk("single_strobes", 64'(n_strobe), 64'd1);
      en = 1'b0;
      tick(1);
      chk("single_idle_busy", 64'(busy), 64'd0);
      chk("single_idle_phi", 64'(phi_inc_o), 64'd0);
      chk("single_idle_clken", 64'(nco_clken), 64'd0);

      // Asynchronous reset in the middle of a dwell.
      en = 1'b1;
      c = cyc;
      expect_hop(32'h0ABC_0000, c + 2);
      drive_cmd(32'h0ABC_0000, 16'd8);
      tick(2 + LAT + 3);
      chk("pre_reset_settled", 64'(settled), 64'd1);
      #3 reset = 1'b1;
      #1 chk_reset_outputs("mid_dwell_rst");
      en = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(2);

      // Fill the FIFO with en low, reject a fifth, then run the four hops.
      s0 = n_strobe;
      for (int i = 0; i < 4; i++) drive_cmd(t3_phi[i], 16'(t3_dw[i]));
      chk("fill_ready", 64'(cmd_ready), 64'd0);
      drive_cmd(32'hDEAD_BEEF, 16'd2);
      c = cyc;
      t = c + 2;
      for (int i = 0; i < 4; i++) begin
         expect_hop(t3_phi[i], t);
         t += 1 + LAT + ((t3_dw[i] > 0) ? t3_dw[i] : 1);
      end
      en = 1'b1;
      tick(t - c + 5);
      chk("fill_strobes", 64'(n_strobe - s0), 64'd4);
      chk("fill_sb_empty", 64'(sb.size()), 64'd0);
      chk("fill_hold_phi", 64'(phi_inc_o), 64'(t3_phi[3]));
      en = 1'b0;
      tick(2);

      // Back-to-back zero-dwell hops are 1 + LAT + 1 clocks apart.
      s0 = n_strobe;
      en = 1'b1;
      c = cyc;
      expect_hop(32'h0055_0000, c + 2);
      expect_hop(32'h0066_0000, c + 2 + 1 + LAT + 1);
      drive_cmd(32'h0055_0000, 16'd0);
      drive_cmd(32'h0066_0000, 16'd0);
      tick(30);
      chk("dw0_strobes", 64'(n_strobe - s0), 64'd2);
      chk("dw0_sb_empty", 64'(sb.size()), 64'd0);
      en = 1'b0;
      tick(2);

      // Abort during SETTLE of hop 2 of 3; a push in the abort cycle is dropped.
      s0 = n_strobe;
      drive_cmd(32'h0C01_0000, 16'd2);
      drive_cmd(32'h0C02_0000, 16'd2);
      drive_cmd(32'h0C03_0000, 16'd2);
      c = cyc;
      expect_hop(32'h0C01_0000, c + 2);
      expect_hop(32'h0C02_0000, c + 2 + 1 + LAT + 2);
      en = 1'b1;
      tick(18);
      chk("pre_abort_busy", 64'(busy), 64'd1);
      abort       = 1'b1;
      cmd_valid   = 1'b1;
      cmd_phi_inc = 32'h7777_0000;
      cmd_dwell   = 16'd1;
      tick(1);
      abort     = 1'b0;
      cmd_valid = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_phi", 64'(phi_inc_o), 64'd0);
      chk("abort_settled", 64'(settled), 64'd0);
      tick(40);
      chk("abort_strobes", 64'(n_strobe - s0), 64'd2);
      chk("abort_sb_empty", 64'(sb.size()), 64'd0);
      chk("abort_ready", 64'(cmd_ready), 64'd1);
      chk("abort_idle", 64'(busy), 64'd0);
      en = 1'b0;
`endif
      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
